// File: rtl/conv_run_harness.sv
// conv_run_harness: multi-run go/finish sequencer and output checker for the
// convolution engine. It issues one go pulse per run, snoops output-RAM writes
// into a shadow buffer, and compares the shadow against an external
// expected-data memory after each run. A watchdog aborts a run whose finish
// never arrives.
// Optional feature: define HARNESS_FIRST_ERR_EN to add first_err_addr,
// first_err_data and first_err_vld. These capture the first mismatch since
// start.
module conv_run_harness #(
  parameter int DATA_W     = 16,
  parameter int OUT_ADDR_W = 3,
  parameter int OUT_DEPTH  = 8,
  parameter int RUNS_W     = 4,
  parameter int TIMEOUT    = 8192,
  parameter int GO_DELAY   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RUNS_W-1:0]            num_runs,
  output logic                         xxx__dut__go,
  input  logic                         dut__xxx__finish,
  input  logic [OUT_ADDR_W-1:0]        dut__dom__address,
  input  logic [DATA_W-1:0]            dut__dom__data,
  input  logic                         dut__dom__enable,
  input  logic                         dut__dom__write,
  output logic [RUNS_W+OUT_ADDR_W-1:0] exp_address,
  input  logic [DATA_W-1:0]            exp_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [15:0]                  err_count,
  output logic [RUNS_W-1:0]            run_idx
`ifdef HARNESS_FIRST_ERR_EN
  ,
  output logic [RUNS_W+OUT_ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0]            first_err_data,
  output logic                         first_err_vld
`endif
);

  localparam int CHK_W = OUT_ADDR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int DLY_W = $clog2(GO_DELAY + 1) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((GO_DELAY > 0) ? GO_DELAY - 1 : 0);
  localparam logic [CHK_W-1:0] CHK_END  = CHK_W'(OUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_GO, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t                  state_q;
  logic [RUNS_W-1:0]       runs_q;
  logic [RUNS_W-1:0]       run_idx_q;
  logic [DLY_W-1:0]        dly_q;
  logic [WD_W-1:0]         wd_q;
  logic [CHK_W-1:0]        chk_q;
  logic                    fin_prev_q;
  logic [OUT_DEPTH-1:0]    valid_q;
  logic                    valid_rd_q;
  logic                    cmp_vld_q;
  logic                    go_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    timeout_q;
  logic [15:0]             err_q;
  logic [DATA_W-1:0]       shadow_rd_q;
  logic [DATA_W-1:0]       shadow_mem [OUT_DEPTH];
`ifdef HARNESS_FIRST_ERR_EN
  logic [RUNS_W+OUT_ADDR_W-1:0] cmp_addr_q;
  logic [RUNS_W+OUT_ADDR_W-1:0] first_addr_q;
  logic [DATA_W-1:0]            first_data_q;
  logic                         first_vld_q;
`endif

  logic                  snoop_we;
  logic                  addr_in_range;
  logic                  fin_rise;
  logic                  wait_wr;
  logic                  oob_wr;
  logic                  mismatch;
  logic [OUT_ADDR_W-1:0] chk_idx;

  assign snoop_we      = dut__dom__enable & dut__dom__write;
  assign addr_in_range = ({1'b0, dut__dom__address} < CHK_END);
  assign fin_rise      = dut__xxx__finish & ~fin_prev_q;
  assign wait_wr       = (state_q == S_WAIT) & snoop_we & addr_in_range;
  assign oob_wr        = (state_q == S_WAIT) & snoop_we & ~addr_in_range;
  assign chk_idx       = chk_q[OUT_ADDR_W-1:0];
  // The compare lags the address by one cycle, matching the expected memory's read latency.
  assign mismatch      = (state_q == S_CHECK) & cmp_vld_q &
                         (~valid_rd_q | (exp_data != shadow_rd_q));

  // Shadow buffer: written by snooped in-range writes, read one word per CHECK cycle.
  always_ff @(posedge clk) begin
    if (wait_wr) shadow_mem[dut__dom__address] <= dut__dom__data;
    shadow_rd_q <= shadow_mem[chk_idx];
  end

  // Run sequencer FSM with watchdog, shadow valid tracking and error counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      runs_q     <= '0;
      run_idx_q  <= '0;
      dly_q      <= '0;
      wd_q       <= '0;
      chk_q      <= '0;
      fin_prev_q <= 1'b0;
      valid_q    <= '0;
      valid_rd_q <= 1'b0;
      cmp_vld_q  <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
`ifdef HARNESS_FIRST_ERR_EN
      cmp_addr_q   <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
      first_vld_q  <= 1'b0;
`endif
    end else begin
      // The edge detector tracks finish in every state, so a level held across GO never re-triggers.
      fin_prev_q <= dut__xxx__finish;
      go_q       <= 1'b0;
      cmp_vld_q  <= 1'b0;
      if ((mismatch | oob_wr) && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
`ifdef HARNESS_FIRST_ERR_EN
      if (mismatch && !first_vld_q) begin
        first_vld_q  <= 1'b1;
        first_addr_q <= cmp_addr_q;
        first_data_q <= shadow_rd_q;
      end
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            runs_q    <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
            err_q     <= '0;
            timeout_q <= 1'b0;
            run_idx_q <= '0;
            valid_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef HARNESS_FIRST_ERR_EN
            first_vld_q  <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
`endif
            if (GO_DELAY == 0) begin
              state_q <= S_GO;
              go_q    <= 1'b1;
              wd_q    <= '0;
            end else begin
              state_q <= S_DELAY;
              dly_q   <= '0;
            end
          end
        end
        S_DELAY: begin
          if (dly_q == DLY_LAST) begin
            state_q <= S_GO;
            go_q    <= 1'b1;
            wd_q    <= '0;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end
        S_GO: begin
          // The go cycle already counts toward the watchdog.
          state_q <= S_WAIT;
          wd_q    <= wd_q + WD_W'(1);
        end
        S_WAIT: begin
          if (wait_wr) valid_q[dut__dom__address] <= 1'b1;
          if (fin_rise) begin
            state_q <= S_CHECK;
            chk_q   <= '0;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_CHECK: begin
          if (chk_q == CHK_END) begin
            state_q <= S_NEXT;
          end else begin
            cmp_vld_q  <= 1'b1;
            valid_rd_q <= valid_q[chk_idx];
`ifdef HARNESS_FIRST_ERR_EN
            cmp_addr_q <= exp_address;
`endif
            chk_q      <= chk_q + CHK_W'(1);
          end
        end
        S_NEXT: begin
          if (run_idx_q == runs_q - RUNS_W'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            run_idx_q <= run_idx_q + RUNS_W'(1);
            valid_q   <= '0;
            if (GO_DELAY == 0) begin
              state_q <= S_GO;
              go_q    <= 1'b1;
              wd_q    <= '0;
            end else begin
              state_q <= S_DELAY;
              dly_q   <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xxx__dut__go = go_q;
  assign exp_address  = {run_idx_q, chk_idx};
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = done_q & (err_q == 16'd0) & ~timeout_q;
  assign timeout      = timeout_q;
  assign err_count    = err_q;
  assign run_idx      = run_idx_q;
`ifdef HARNESS_FIRST_ERR_EN
  assign first_err_addr = first_addr_q;
  assign first_err_data = first_data_q;
  assign first_err_vld  = first_vld_q;
`endif

endmodule

// File: tb/tb_conv_run_harness.sv
// Directed testbench for conv_run_harness: a small DUT model drives go/finish
// and output-RAM writes, and a synchronous-read array serves expected data.
module tb_conv_run_harness;
  localparam int GO_DELAY = 4;
  localparam int TIMEOUT  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_runs = '0;
  logic        go;
  logic        finish = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        wen = 1'b0;
  logic        wwr = 1'b0;
  logic [6:0]  exp_address;
  logic [15:0] exp_data = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [3:0]  run_idx;
`ifdef HARNESS_FIRST_ERR_EN
  logic [6:0]  first_err_addr;
  logic [15:0] first_err_data;
  logic        first_err_vld;
`endif

  int vectors = 0;
  int miscompares = 0;
  int go_cnt = 0;
  logic [15:0] exp_mem [128];
  logic [2:0]  op_addr [16];
  logic [15:0] op_data [16];
  int          op_n = 0;

  conv_run_harness #(
    .DATA_W(16), .OUT_ADDR_W(3), .OUT_DEPTH(8), .RUNS_W(4),
    .TIMEOUT(TIMEOUT), .GO_DELAY(GO_DELAY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs),
    .xxx__dut__go(go), .dut__xxx__finish(finish),
    .dut__dom__address(waddr), .dut__dom__data(wdata),
    .dut__dom__enable(wen), .dut__dom__write(wwr),
    .exp_address(exp_address), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .run_idx(run_idx)
`ifdef HARNESS_FIRST_ERR_EN
    , .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .first_err_vld(first_err_vld)
`endif
  );

  always #5 clk = ~clk;

  // expected memory: one cycle read latency
  always @(posedge clk) exp_data <= exp_mem[exp_address];

  // count every cycle go is high (a stretched pulse shows up as extra counts)
  always @(posedge clk) if (go === 1'b1) go_cnt <= go_cnt + 1;

  task automatic set_std();
    op_n = 8;
    for (int i = 0; i < 8; i++) begin
      op_addr[i] = 3'(i);
      op_data[i] = 16'h1000 + 16'(i);
    end
  endtask

  task automatic do_start(input logic [3:0] n);
    @(posedge clk); #1;
    num_runs = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // wait for go, then play the write list; fin_after==0 raises finish with the last write
  task automatic dut_serve(input int fin_after, output int waited);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (go !== 1'b1 && waited < 300);
    vectors++;
    if (go !== 1'b1) begin
      miscompares++;
      $display("FAIL go_wait got no go within %0d cycles, want go pulse", waited);
      return;
    end
    @(posedge clk); #1;
    for (int i = 0; i < op_n; i++) begin
      waddr = op_addr[i];
      wdata = op_data[i];
      wen = 1'b1;
      wwr = 1'b1;
      if (fin_after == 0 && i == op_n - 1) finish = 1'b1;
      @(posedge clk); #1;
    end
    wen = 1'b0;
    wwr = 1'b0;
    finish = 1'b0;
    if (fin_after > 0) begin
      repeat (fin_after) @(posedge clk);
      #1 finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_wait got done=%b after %0d cycles, want 1", done, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({go, busy, done, pass, timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {go, busy, done, pass, timeout});
    end
    vectors++;
    if (err_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_err got %h want 0000", err_count);
    end
    vectors++;
    if ({run_idx, exp_address} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_idx got %h want 000", {run_idx, exp_address});
    end
`ifdef HARNESS_FIRST_ERR_EN
    vectors++;
    if (first_err_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_vld got %b want 0", first_err_vld);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_single_run();
    int w, g0;
    set_std();
    g0 = go_cnt;
    do_start(4'd1);
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_busy got busy,done=%b want 10", {busy, done});
    end
    dut_serve(192, w);
    vectors++;
    if (w + 1 !== GO_DELAY + 1) begin
      miscompares++;
      $display("FAIL single_go_latency got %0d want %0d", w + 1, GO_DELAY + 1);
    end
    wait_done();
    vectors++;
    if ({done, pass, timeout, busy} !== 4'b1100) begin
      miscompares++;
      $display("FAIL single_status got done,pass,timeout,busy=%b want 1100", {done, pass, timeout, busy});
    end
    vectors++;
    if (err_count !== 16'h0) begin
      miscompares++;
      $display("FAIL single_err got %h want 0000", err_count);
    end
    vectors++;
    if (run_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL single_run_idx got %0d want 0", run_idx);
    end
    vectors++;
    if (go_cnt - g0 !== 1) begin
      miscompares++;
      $display("FAIL single_go_count got %0d want 1", go_cnt - g0);
    end
  endtask

  task automatic test_multi_run();
    int w, g0;
    logic [6:0] ea;
    ea = {4'd1, 3'd5};
    exp_mem[ea] = 16'h0005;
    g0 = go_cnt;
    do_start(4'd3);
    for (int r = 0; r < 3; r++) begin
      set_std();
      if (r == 1) op_data[5] = 16'hBEEF;
      dut_serve(5, w);
    end
    wait_done();
    vectors++;
    if (err_count !== 16'd1) begin
      miscompares++;
      $display("FAIL multi_err got %0d want 1", err_count);
    end
    vectors++;
    if (pass !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_pass got %b want 0", pass);
    end
    vectors++;
    if (go_cnt - g0 !== 3) begin
      miscompares++;
      $display("FAIL multi_go_count got %0d want 3", go_cnt - g0);
    end
    vectors++;
    if (run_idx !== 4'd2) begin
      miscompares++;
      $display("FAIL multi_run_idx got %0d want 2", run_idx);
    end
    exp_mem[ea] = 16'h1005;
  endtask

  task automatic test_missing_overwrite();
    int w;
    do_start(4'd1);
    vectors++;
    if ({err_count, done} !== 17'h0) begin
      miscompares++;
      $display("FAIL restart_clear got err=%h done=%b want 0000/0", err_count, done);
    end
    op_n = 8;
    op_addr[0] = 3'd3;
    op_data[0] = 16'h0000;
    for (int i = 1; i < 8; i++) begin
      op_addr[i] = 3'(i - 1);
      op_data[i] = 16'h1000 + 16'(i - 1);
    end
    dut_serve(0, w);
    wait_done();
    vectors++;
    if (err_count !== 16'd1) begin
      miscompares++;
      $display("FAIL missing_err got %0d want 1", err_count);
    end
    vectors++;
    if (pass !== 1'b0) begin
      miscompares++;
      $display("FAIL missing_pass got %b want 0", pass);
    end
  endtask

  task automatic test_timeout();
    int n, g0;
    do_start(4'd2);
    vectors++;
    if (err_count !== 16'h0) begin
      miscompares++;
      $display("FAIL timeout_err_clear got %h want 0000", err_count);
    end
    n = 0;
    while (go !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    while (timeout !== 1'b1 && n < TIMEOUT + 500) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n !== TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_latency got %0d cycles want %0d", n, TIMEOUT);
    end
    vectors++;
    if ({done, pass, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout_status got done,pass,busy=%b want 100", {done, pass, busy});
    end
    g0 = go_cnt;
    repeat (50) @(posedge clk);
    #1;
    vectors++;
    if (go_cnt - g0 !== 0) begin
      miscompares++;
      $display("FAIL timeout_no_more_go got %0d want 0", go_cnt - g0);
    end
    vectors++;
    if (run_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL timeout_run_idx got %0d want 0", run_idx);
    end
  endtask

  task automatic test_reset_mid();
    int w, n;
    do_start(4'd3);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_timeout_clear got %b want 0", timeout);
    end
    set_std();
    op_n = 7;
    dut_serve(3, w);
    n = 0;
    while (go !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({err_count, run_idx} !== {16'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL midwait_pre got err=%0d run=%0d want 1/1", err_count, run_idx);
    end
    reset = 1'b0;
    #2;
    vectors++;
    if ({go, busy, done, pass, timeout} !== 5'b0 || err_count !== 16'h0 || run_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL midwait_reset got flags=%b err=%h run=%0d want 00000/0000/0",
               {go, busy, done, pass, timeout}, err_count, run_idx);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    set_std();
    do_start(4'd1);
    vectors++;
    if ({busy, run_idx, err_count} !== {1'b1, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL post_reset_start got busy=%b run=%0d err=%0d want 1/0/0", busy, run_idx, err_count);
    end
    dut_serve(3, w);
    wait_done();
    vectors++;
    if (pass !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_pass got %b want 1", pass);
    end
  endtask

`ifdef HARNESS_FIRST_ERR_EN
  task automatic test_first_err();
    int w;
    do_start(4'd2);
    vectors++;
    if (first_err_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL first_vld_clear got %b want 0", first_err_vld);
    end
    set_std();
    op_data[2] = 16'hDEAD;
    dut_serve(3, w);
    set_std();
    op_data[4] = 16'hCAFE;
    dut_serve(3, w);
    wait_done();
    vectors++;
    if (err_count !== 16'd2) begin
      miscompares++;
      $display("FAIL first_err_count got %0d want 2", err_count);
    end
    vectors++;
    if ({first_err_vld, first_err_addr} !== {1'b1, 7'h02}) begin
      miscompares++;
      $display("FAIL first_err_addr got vld=%b addr=%h want 1/02", first_err_vld, first_err_addr);
    end
    vectors++;
    if (first_err_data !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL first_err_data got %h want DEAD", first_err_data);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 128; a++) exp_mem[a] = 16'h1000 + 16'(a % 8);
    test_reset();
    test_single_run();
    test_multi_run();
    test_missing_overwrite();
    test_timeout();
    test_reset_mid();
`ifdef HARNESS_FIRST_ERR_EN
    test_first_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
